// File: rtl/cdc_pkg.sv
// Shared types and constants for the CDC handshake receiver slice.
package cdc_pkg;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      ACK
   } rx_state_t;

   localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module bit_synchronizer
   import cdc_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_Async,
   output logic o_Sync
);

   generate
      if (STAGES < MIN_SYNC_STAGES) begin : g_stage_check
         $error("bit_synchronizer: STAGES must be at least %0d", MIN_SYNC_STAGES);
      end
   endgenerate

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], i_Async};
      end
   end

   assign o_Sync = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_receiver.sv
// Destination side of a 4-phase req/ack handshake: synchronises the request,
// captures the quasi-static source word and returns the acknowledge.
module cdc_handshake_receiver
   import cdc_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  i_Req,
   input  logic [DATA_WIDTH-1:0] i_Src_Data,
   output logic                  o_Ack,
   output logic [DATA_WIDTH-1:0] o_Output_Data,
   output logic                  o_Data_Valid,
   output logic                  o_Busy,
   output logic [CNT_WIDTH-1:0]  o_Xfer_Count
);

   localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

   logic                req_s;
   rx_state_t           state;
   logic [SETTLE_W-1:0] settle;

   bit_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk     (clk),
      .resetn  (resetn),
      .i_Async (i_Req),
      .o_Sync  (req_s)
   );

   // The chain comes out of reset all zero, so req_s only reflects the real
   // i_Req after SYNC_STAGES edges; INIT waits that long before trusting a
   // low req_s, otherwise a request held across reset would be captured again.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= INIT;
         settle        <= '0;
         o_Ack         <= 1'b0;
         o_Output_Data <= '0;
         o_Data_Valid  <= 1'b0;
         o_Busy        <= 1'b1;
         o_Xfer_Count  <= '0;
      end else begin
         o_Data_Valid <= 1'b0;
         case (state)
            INIT: begin
               if (settle != SETTLE_W'(SYNC_STAGES)) begin
                  settle <= settle + SETTLE_W'(1);
               end else if (!req_s) begin
                  state  <= IDLE;
                  o_Busy <= 1'b0;
               end
            end
            IDLE: begin
               if (req_s) begin
                  o_Output_Data <= i_Src_Data;
                  o_Data_Valid  <= 1'b1;
                  o_Ack         <= 1'b1;
                  o_Xfer_Count  <= o_Xfer_Count + CNT_WIDTH'(1);
                  o_Busy        <= 1'b1;
                  state         <= ACK;
               end
            end
            ACK: begin
               if (!req_s) begin
                  o_Ack  <= 1'b0;
                  o_Busy <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state  <= INIT;
               settle <= '0;
               o_Ack  <= 1'b0;
               o_Busy <= 1'b1;
            end
         endcase
      end
   end

endmodule
